// File: rtl/razor_recovery_ctrl.sv
// razor_recovery_ctrl: collects shadow-latch timing-error flags, runs a
// stall -> flush -> replay recovery for each error event, counts error cycles
// and steps a DVFS margin level once per observation window.
// Interface note: all inputs are sampled on posedge clk. All control outputs
// come straight from flops. There is no handshake; every error flag is
// treated as a level-sampled event once per cycle.
module razor_recovery_ctrl #(
    parameter int N_DET         = 8,
    parameter int REPLAY_CYCLES = 2,
    parameter int WINDOW        = 256,
    parameter int THRESH        = 4,
    parameter int LVL_W         = 3,
    parameter int LVL_RESET     = 3,
    localparam int SRC_W        = (N_DET > 1) ? $clog2(N_DET) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic [N_DET-1:0] error_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic             replay_o,
    output logic             busy_o,
    output logic [SRC_W-1:0] err_src_o,
    output logic [15:0]      err_count_o,
    output logic [LVL_W-1:0] dvfs_level_o,
    output logic             level_change_o,
    output logic [1:0]       dbg_state_o
);

    localparam int RC_W  = (REPLAY_CYCLES > 1) ? $clog2(REPLAY_CYCLES) : 1;
    localparam int WIN_W = $clog2(WINDOW);
    localparam int WE_W  = $clog2(THRESH + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = {LVL_W{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, REPLAY = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic             pend_q, pend_d;
    logic [SRC_W-1:0] psrc_q, psrc_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WE_W-1:0]  werr_q, werr_d, werr_sum;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             chg_q, chg_d;
    logic             stall_q, flush_q, replay_q;
    logic [SRC_W-1:0] src_now;
    logic             err_evt;

    // Lowest-index set error bit; descending overwrite leaves the lowest.
    always_comb begin
        src_now = '0;
        for (int i = N_DET - 1; i >= 0; i--) begin
            if (error_i[i]) src_now = SRC_W'(i);
        end
    end

    assign err_evt = (|error_i) & enable_i;

    // Recovery FSM next state: one pending slot captures the first error seen
    // while a recovery is in flight, including one in the final replay cycle.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pend_d  = pend_q;
        psrc_d  = psrc_q;
        src_d   = src_q;
        case (state_q)
            IDLE: begin
                if (err_evt) begin
                    state_d = FLUSH;
                    src_d   = src_now;
                end
            end
            FLUSH: begin
                state_d = REPLAY;
                rcnt_d  = '0;
                if (err_evt && !pend_q) begin
                    pend_d = 1'b1;
                    psrc_d = src_now;
                end
            end
            REPLAY: begin
                if (err_evt && !pend_q) begin
                    pend_d = 1'b1;
                    psrc_d = src_now;
                end
                if (rcnt_q == RC_W'(REPLAY_CYCLES - 1)) begin
                    if (pend_q || err_evt) begin
                        state_d = FLUSH;
                        pend_d  = 1'b0;
                        src_d   = pend_q ? psrc_q : src_now;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Error counter and window-based level adaptation.
    always_comb begin
        cnt_d    = cnt_q;
        win_d    = win_q;
        werr_d   = werr_q;
        lvl_d    = lvl_q;
        chg_d    = 1'b0;
        werr_sum = werr_q;
        if (err_evt && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (enable_i) begin
            if (err_evt && werr_q < WE_W'(THRESH)) werr_sum = werr_q + 1'b1;
            if (win_q == WIN_W'(WINDOW - 1)) begin
                win_d  = '0;
                werr_d = '0;
                if (werr_sum >= WE_W'(THRESH) && lvl_q != LVL_MAX) begin
                    lvl_d = lvl_q + 1'b1;
                    chg_d = 1'b1;
                end else if (werr_sum == '0 && lvl_q != '0) begin
                    lvl_d = lvl_q - 1'b1;
                    chg_d = 1'b1;
                end
            end else begin
                win_d  = win_q + 1'b1;
                werr_d = werr_sum;
            end
        end
    end

    // State and output registers; strobes are decoded from the next state so
    // they appear one cycle after the triggering error, glitch-free.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            rcnt_q   <= '0;
            pend_q   <= 1'b0;
            psrc_q   <= '0;
            src_q    <= '0;
            cnt_q    <= '0;
            win_q    <= '0;
            werr_q   <= '0;
            lvl_q    <= LVL_W'(LVL_RESET);
            chg_q    <= 1'b0;
            stall_q  <= 1'b0;
            flush_q  <= 1'b0;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            pend_q   <= pend_d;
            psrc_q   <= psrc_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            werr_q   <= werr_d;
            lvl_q    <= lvl_d;
            chg_q    <= chg_d;
            stall_q  <= (state_d != IDLE);
            flush_q  <= (state_d == FLUSH);
            replay_q <= (state_d == REPLAY);
        end
    end

    assign stall_o        = stall_q;
    assign busy_o         = stall_q;
    assign flush_o        = flush_q;
    assign replay_o       = replay_q;
    assign err_src_o      = src_q;
    assign err_count_o    = cnt_q;
    assign dvfs_level_o   = lvl_q;
    assign level_change_o = chg_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_razor_recovery_ctrl.sv
// Testbench for razor_recovery_ctrl: recovery sequencing, error counting and
// window-driven level adaptation, with a second instance reset to level 0.
module tb_razor_recovery_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable_i = 1'b0;
  logic [7:0] error_i = 8'h00;

  logic       stall_o, flush_o, replay_o, busy_o, level_change_o;
  logic [2:0] err_src_o, dvfs_level_o;
  logic [15:0] err_count_o;
  logic [1:0] dbg_state_o;

  logic       stall0, flush0, replay0, busy0, chg0;
  logic [2:0] src0, lvl0;
  logic [15:0] cnt0;
  logic [1:0] st0;
  logic [7:0] zero_err = 8'h00;

  int n_tests = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  logic [3:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  razor_recovery_ctrl dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .error_i(error_i),
    .stall_o(stall_o), .flush_o(flush_o), .replay_o(replay_o), .busy_o(busy_o),
    .err_src_o(err_src_o), .err_count_o(err_count_o), .dvfs_level_o(dvfs_level_o),
    .level_change_o(level_change_o), .dbg_state_o(dbg_state_o)
  );

  razor_recovery_ctrl #(.LVL_RESET(0)) dut0 (
    .clk(clk), .reset(reset), .enable_i(enable_i), .error_i(zero_err),
    .stall_o(stall0), .flush_o(flush0), .replay_o(replay0), .busy_o(busy0),
    .err_src_o(src0), .err_count_o(cnt0), .dvfs_level_o(lvl0),
    .level_change_o(chg0), .dbg_state_o(st0)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] e);
    error_i = e;
    if (enable_i && (e != 8'h00)) exp_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    error_i = 8'h00;
    step();
    reset = 1'b1;
    enable_i = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable_i = 1'b1;
    error_i = 8'hFF;
    repeat (3) step();
    n_tests++;
    if ({stall_o, flush_o, replay_o, busy_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 0000", {stall_o, flush_o, replay_o, busy_o});
    end
    n_tests++;
    if (err_count_o !== 16'd0 || err_src_o !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_count: got cnt=%0d src=%0d required 0/0", err_count_o, err_src_o);
    end
    n_tests++;
    if (dvfs_level_o !== 3'd3 || level_change_o !== 1'b0 || lvl0 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_level: got %0d/%b lvl0=%0d required 3/0 lvl0=0", dvfs_level_o, level_change_o, lvl0);
    end
    error_i = 8'h00;
    reset = 1'b1;
    exp_cnt = 0;
  endtask

  // Sequence {stall,flush,replay,busy}: F=1101, R=1011, I=0000.
  task automatic test_single_error();
    logic [7:0] errs[$];
    logic [3:0] exp;
    errs = '{8'b0010_0100, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      drive(errs[i]);
      exp_q.push_back((i == 0) ? 4'b1101 : (i < 3) ? 4'b1011 : 4'b0000);
      step();
      exp = exp_q.pop_front();
      n_tests++;
      if ({stall_o, flush_o, replay_o, busy_o} !== exp) begin
        n_fail++;
        $display("FAIL single_seq[%0d]: got %b required %b", i, {stall_o, flush_o, replay_o, busy_o}, exp);
      end
      if (i == 0) begin
        n_tests++;
        if (err_src_o !== 3'd2) begin
          n_fail++;
          $display("FAIL single_src: got %0d required 2", err_src_o);
        end
      end
    end
    drive(8'h00);
    n_tests++;
    if (err_count_o !== 16'(exp_cnt) || exp_cnt != 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d required 1", err_count_o);
    end
  endtask

  task automatic test_nested_error();
    logic [7:0] errs[$];
    logic [3:0] seq[$];
    logic [3:0] exp;
    int base;
    base = exp_cnt;
    errs = '{8'h01, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    seq  = '{4'b1101, 4'b1011, 4'b1011, 4'b1101, 4'b1011, 4'b1011, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      drive(errs[i]);
      exp_q.push_back(seq[i]);
      step();
      exp = exp_q.pop_front();
      n_tests++;
      if ({stall_o, flush_o, replay_o, busy_o} !== exp) begin
        n_fail++;
        $display("FAIL nested_seq[%0d]: got %b required %b", i, {stall_o, flush_o, replay_o, busy_o}, exp);
      end
      if (i == 0 || i == 3) begin
        n_tests++;
        if (err_src_o !== ((i == 0) ? 3'd0 : 3'd7)) begin
          n_fail++;
          $display("FAIL nested_src[%0d]: got %0d required %0d", i, err_src_o, (i == 0) ? 0 : 7);
        end
      end
    end
    drive(8'h00);
    n_tests++;
    if (err_count_o !== 16'(base + 2)) begin
      n_fail++;
      $display("FAIL nested_count: got %0d required %0d", err_count_o, base + 2);
    end
  endtask

  // Error lands in the final replay cycle: stall must stay high throughout.
  task automatic test_back_to_back();
    logic [7:0] errs[$];
    logic [3:0] seq[$];
    logic [3:0] exp;
    errs = '{8'h03, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00};
    seq  = '{4'b1101, 4'b1011, 4'b1011, 4'b1101, 4'b1011, 4'b1011, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      drive(errs[i]);
      exp_q.push_back(seq[i]);
      step();
      exp = exp_q.pop_front();
      n_tests++;
      if ({stall_o, flush_o, replay_o, busy_o} !== exp) begin
        n_fail++;
        $display("FAIL b2b_seq[%0d]: got %b required %b", i, {stall_o, flush_o, replay_o, busy_o}, exp);
      end
      if (i == 3) begin
        n_tests++;
        if (err_src_o !== 3'd4) begin
          n_fail++;
          $display("FAIL b2b_src: got %0d required 4", err_src_o);
        end
      end
    end
    drive(8'h00);
    n_tests++;
    if (err_count_o !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d required %0d", err_count_o, exp_cnt);
    end
  endtask

  task automatic test_enable_off();
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7)));
      exp_q.push_back(4'b0000);
      step();
      n_tests++;
      if ({stall_o, flush_o, replay_o, busy_o} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL enable_off_seq[%0d]: got %b required %b", i, {stall_o, flush_o, replay_o, busy_o}, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    drive(8'h00);
    n_tests++;
    if (err_count_o !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL enable_off_count: got %0d required %0d", err_count_o, exp_cnt);
    end
    enable_i = 1'b1;
  endtask

  task automatic test_reset_in_replay();
    drive(8'h40);
    step();
    drive(8'h00);
    step();
    n_tests++;
    if (replay_o !== 1'b1 || err_src_o !== 3'd6) begin
      n_fail++;
      $display("FAIL rir_pre: got replay=%b src=%0d required 1/6", replay_o, err_src_o);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if ({stall_o, flush_o, replay_o, busy_o, level_change_o} !== 5'b00000 ||
        err_src_o !== 3'd0 || err_count_o !== 16'd0 || dvfs_level_o !== 3'd3 || dbg_state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL rir_post: got strobes=%b src=%0d cnt=%0d lvl=%0d st=%0d required 00000/0/0/3/0",
               {stall_o, flush_o, replay_o, busy_o, level_change_o}, err_src_o, err_count_o, dvfs_level_o, dbg_state_o);
    end
    reset = 1'b1;
    exp_cnt = 0;
  endtask

  // Four errors in the window, the last on the final cycle itself.
  task automatic test_window_up();
    logic [3:0] exp;
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 262; i++) begin
      drive((i == 10 || i == 50 || i == 90 || i == 255) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      exp_q.push_back({(i == 255), (i < 255) ? 3'd3 : 3'd4});
      step();
      exp = exp_q.pop_front();
      if (level_change_o) pulses++;
      if (i >= 250) begin
        n_tests++;
        if ({level_change_o, dvfs_level_o} !== exp) begin
          n_fail++;
          $display("FAIL window_up[%0d]: got chg/lvl=%b required %b", i, {level_change_o, dvfs_level_o}, exp);
        end
      end
    end
    drive(8'h00);
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL window_up_pulses: got %0d required 1", pulses);
    end
  endtask

  // Error-free window, with a 20-cycle enable gap that must freeze it.
  task automatic test_window_down();
    logic [3:0] exp;
    int pulses;
    int pulses0;
    pulses = 0;
    pulses0 = 0;
    do_reset();
    for (int i = 0; i < 280; i++) begin
      enable_i = !(i >= 100 && i < 120);
      drive(8'h00);
      exp_q.push_back({(i == 275), (i < 275) ? 3'd3 : 3'd2});
      step();
      exp = exp_q.pop_front();
      if (level_change_o) pulses++;
      if (chg0) pulses0++;
      if (i >= 250 || (i >= 100 && i < 125)) begin
        n_tests++;
        if ({level_change_o, dvfs_level_o} !== exp) begin
          n_fail++;
          $display("FAIL window_down[%0d]: got chg/lvl=%b required %b", i, {level_change_o, dvfs_level_o}, exp);
        end
      end
    end
    enable_i = 1'b1;
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL window_down_pulses: got %0d required 1", pulses);
    end
    n_tests++;
    if (lvl0 !== 3'd0 || pulses0 != 0) begin
      n_fail++;
      $display("FAIL window_floor: got lvl0=%0d pulses=%0d required 0/0", lvl0, pulses0);
    end
  endtask

  initial begin
    test_reset();
    step();
    test_single_error();
    test_nested_error();
    test_back_to_back();
    test_enable_off();
    test_reset_in_replay();
    test_window_up();
    test_window_down();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
